// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
// Provides the responder state encoding, the data word width and a
// constant-function log2 used to size the word index.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port DEPTH x WORD_W storage with synchronous write and a
// registered read port. The array itself is never cleared by reset; only
// the read register is, so a responder reset leaves stored words intact.
module sp_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store the write word when an enabled access is a write.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register: cleared by reset, loaded only by enabled reads, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory port responder for the multi-cycle CPU.
// Accepts one request in IDLE, waits WAIT_CYCLES cycles, then performs the
// access on entry to RESP and pulses ready for one cycle.
// Optional build macro DMEM_MISALIGN_CHK_EN adds an err output that flags
// accesses whose byte address is not word aligned; such accesses are
// suppressed but still take the full latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              busy
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              lat_we;
  logic [IDX_W-1:0]  lat_idx;
  logic [WORD_W-1:0] lat_wdata;
  logic              lat_mis;
  logic [IDX_W-1:0]  in_idx;
  logic              in_mis;
  logic              ram_en;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] ram_wdata;
  logic              unused_addr_bits;

  assign in_idx           = addr[IDX_W+1:2];
  assign unused_addr_bits = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
  assign in_mis = (addr[1:0] != 2'b00);
`else
  assign in_mis = 1'b0;
`endif

  // With zero wait states the access happens on the acceptance edge, so the
  // RAM must see the live request fields while still in IDLE.
  assign ram_we    = (state == IDLE) ? we     : lat_we;
  assign ram_idx   = (state == IDLE) ? in_idx : lat_idx;
  assign ram_wdata = (state == IDLE) ? wdata  : lat_wdata;

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
`ifdef DMEM_MISALIGN_CHK_EN
  assign err   = (state == RESP) && lat_mis;
`endif

  // State, wait counter and request latches; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        lat_we    <= we;
        lat_idx   <= in_idx;
        lat_wdata <= wdata;
        lat_mis   <= in_mis;
      end
    end
  end

  // Next state and RAM enable; the access fires on the edge that enters RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            ram_en    = !in_mis;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          ram_en    = !lat_mis;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!rst_n) begin
      ram_en = 1'b0;
    end
  end

  sp_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Main instance uses WAIT_CYCLES=2; a second instance with WAIT_CYCLES=0
// exercises back-to-back requests. Expected values come from a word array
// model with a fixed response latency of WAIT_CYCLES+1 sampled cycles.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        busy;
  logic [31:0] rdata;

  logic        req0   = 1'b0;
  logic        we0    = 1'b0;
  logic [31:0] addr0  = '0;
  logic [31:0] wdata0 = '0;
  logic        ready0;
  logic        busy0;
  logic [31:0] rdata0;

`ifdef DMEM_MISALIGN_CHK_EN
  logic        err;
  logic        err0;
`endif

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .rdata (rdata),
    .busy  (busy)
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    .err   (err)
`endif
  );

  dmem_responder #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req0),
    .we    (we0),
    .addr  (addr0),
    .wdata (wdata0),
    .ready (ready0),
    .rdata (rdata0),
    .busy  (busy0)
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    .err   (err0)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    if (obs !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on the main instance, with the request fields
  // scrambled while it is in flight and req held until ready is seen.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    int         cycles;
    logic       mis;
    logic [7:0] idx;
    idx = a[9:2];
`ifdef DMEM_MISALIGN_CHK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'($urandom); addr = $urandom; wdata = $urandom;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles = cycles + 1;
      if (!ready) checkOutput("busy_wait", 32'(busy), 32'd1);
    end while (!ready && cycles < 20);
    req = 1'b0;
    checkOutput("latency", 32'(cycles), 32'(W + 1));
    if (!mis) begin
      if (w) ref_mem[idx] = d;
      else   exp_rdata = ref_mem[idx];
    end
    checkOutput("rdata", rdata, exp_rdata);
    checkOutput("busy_resp", 32'(busy), 32'd1);
`ifdef DMEM_MISALIGN_CHK_EN
    checkOutput("err_resp", 32'(err), 32'(mis));
`endif
    @(negedge clk);
    checkOutput("ready_after", 32'(ready), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
`ifdef DMEM_MISALIGN_CHK_EN
    checkOutput("err_after", 32'(err), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");

    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("rst_ready", 32'(ready), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_ready", 32'(ready), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_rdata", rdata, 32'd0);
    end

    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0);

    applyStimulus(1'b1, 32'h0000_0400, 32'h1111_1111);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0);

    applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("midrst_ready", 32'(ready), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    exp_rdata = '0;
    @(negedge clk);
    checkOutput("midrst_ready2", 32'(ready), 32'd0);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0);

`ifdef DMEM_MISALIGN_CHK_EN
    applyStimulus(1'b1, 32'h0000_0022, 32'h0BAD_0BAD);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0);
`endif

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, ($urandom & 32'hFFFF_FC00) | 32'(i << 2), $urandom);
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'($urandom),
                    ($urandom & 32'hFFFF_FC03) | 32'($urandom_range(0, 15) << 2),
                    $urandom);
    end

    // Back-to-back on the zero-wait instance: 4 writes then 4 reads.
    @(negedge clk);
    we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h0000_1000; req0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("b2b_ready", 32'(ready0), 32'd1);
      checkOutput("b2b_busy", 32'(busy0), 32'd1);
      if (k >= 4) checkOutput("b2b_rdata", rdata0, 32'h0000_1000 + 32'(k - 4));
      if (k < 7) begin
        we0    = (k + 1) < 4;
        addr0  = 32'(((k + 1) % 4) * 4);
        wdata0 = 32'h0000_1000 + 32'(k + 1);
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      checkOutput("b2b_gap_ready", 32'(ready0), 32'd0);
      checkOutput("b2b_gap_busy", 32'(busy0), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
